// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the MEM-stage port.
// It accepts one load or store, waits a programmable number of cycles, then commits
// the access against a word array and presents the result until it is taken.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Request fields held across the wait states.
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q;

    logic        latch_en;
    logic        commit;

    // Access currently being decoded: live inputs when committing straight from IDLE.
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [2:0]  cur_f3;
    logic [31:0] cur_wdata;

    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             fault;
    logic             mem_we;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Fault if funct3 is undefined, a store uses an unsigned width, the offset is
    // outside the array, or the lane is misaligned for the access width.
    function automatic logic access_fault(input logic [2:0] f3, input logic we,
                                          input logic [1:0] ln, input logic rng);
        logic bad;
        case (f3)
            F3_B:         bad = 1'b0;
            F3_H:         bad = ln[0];
            F3_W:         bad = (ln != 2'b00);
            F3_BU:        bad = we;
            F3_HU:        bad = we | ln[0];
            default:      bad = 1'b1;
        endcase
        return bad | ~rng;
    endfunction

    // Byte enables for a store of the given width at the given lane.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] ln);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << ln;
            F3_H:    be = ln[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data replicated onto every lane; the enables pick the lanes.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wd[7:0]}};
            F3_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Lane selection and sign/zero extension of a loaded word.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] ln);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {ln, 3'b000});
        h = ln[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Select the access source and decode address, lane and faults.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_f3    = req_funct3;
            cur_wdata = req_wdata;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_f3    = f3_q;
            cur_wdata = wdata_q;
        end
        offset   = cur_addr - BASE_ADDR;
        in_range = ({1'b0, offset} < SPAN);
        idx      = offset[IDX_W+1:2];
        lane     = cur_addr[1:0];
        fault    = access_fault(cur_f3, cur_we, lane, in_range);
        wr_be    = store_be(cur_f3, lane);
        wr_data  = store_data(cur_f3, cur_wdata);
        rd_word  = mem_q[idx];
        mem_we   = commit & cur_we & ~fault & rstn;
    end

    // Next-state logic for the IDLE -> WAIT -> RESP handshake and the commit result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        latch_en = 1'b0;
        commit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    latch_en = 1'b1;
                    if (NO_WAIT) begin
                        commit  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            err_d   = fault;
            rdata_d = (fault | cur_we) ? 32'd0 : load_extend(rd_word, cur_f3, lane);
        end
    end

    // Control state and the visible response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture the request fields on acceptance; they are meaningless until then.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
        end
    end

    // Byte-enabled array write on a fault-free store commit; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder built with three wait states.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int passed = 0;

    dmem_responder #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(3),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_funct3(req_funct3),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete transaction with resp_ready high; returns response and latency.
    task automatic access(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        n = 0;
        resp_ready = 1'b1;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        if (!resp_valid) begin
            checks++;
            $display("FAIL access_timeout addr=%h: no resp_valid after %0d cycles", addr, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_funct3 = 3'b010; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passed++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else passed++;
        checks++; if (resp_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else passed++;
        checks++; if (resp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", resp_err); else passed++;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, BASE, 3'b010, 32'hDEAD_BEEF, rd, er, lat);
        checks++; if ({er, rd} !== 33'd0) $display("FAIL sw_resp: got err=%b rdata=%h want 0/0", er, rd); else passed++;
        checks++; if (lat !== 3) $display("FAIL sw_latency: got %0d want 3", lat); else passed++;
        access(1'b0, BASE, 3'b010, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) $display("FAIL lw_base: got %h err=%b want deadbeef err=0", rd, er); else passed++;
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, BASE + 4, 3'b010, 32'h1122_3344, rd, er, lat);
        access(1'b1, BASE + 6, 3'b000, 32'h0000_0080, rd, er, lat);
        access(1'b0, BASE + 6, 3'b000, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF_FF80 || er) $display("FAIL lb_neg: got %h want ffffff80", rd); else passed++;
        access(1'b0, BASE + 6, 3'b100, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h0000_0080 || er) $display("FAIL lbu: got %h want 00000080", rd); else passed++;
        access(1'b0, BASE + 4, 3'b010, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h1180_3344) $display("FAIL sb_lanes: got %h want 11803344", rd); else passed++;
        access(1'b0, BASE + 7, 3'b000, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h0000_0011) $display("FAIL lb_pos: got %h want 00000011", rd); else passed++;
        access(1'b0, BASE + 6, 3'b001, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h0000_1180 || er) $display("FAIL lh_upper: got %h want 00001180", rd); else passed++;
        access(1'b1, BASE + 4, 3'b001, 32'hABCD_8001, rd, er, lat);
        access(1'b0, BASE + 4, 3'b001, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF_8001 || er) $display("FAIL lh_neg: got %h want ffff8001", rd); else passed++;
        access(1'b0, BASE + 4, 3'b101, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h0000_8001 || er) $display("FAIL lhu: got %h want 00008001", rd); else passed++;
        access(1'b0, BASE + 4, 3'b010, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h1180_8001) $display("FAIL sh_lanes: got %h want 11808001", rd); else passed++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        access(1'b0, BASE + 2, 3'b010, 32'd0, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL lw_misalign: got err=%b rdata=%h want 1/0", er, rd); else passed++;
        access(1'b1, BASE + 3, 3'b001, 32'h0000_FFFF, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL sh_misalign: got err=%b rdata=%h want 1/0", er, rd); else passed++;
        access(1'b0, BASE, 3'b010, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF || er) $display("FAIL misalign_nowrite: got %h want deadbeef", rd); else passed++;
        access(1'b0, BASE, 3'b011, 32'd0, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL bad_funct3: got err=%b rdata=%h want 1/0", er, rd); else passed++;
        access(1'b1, BASE + 4, 3'b100, 32'd0, rd, er, lat);
        checks++; if (er !== 1'b1) $display("FAIL store_unsigned: got err=%b want 1", er); else passed++;
        access(1'b0, BASE + 4, 3'b010, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h1180_8001) $display("FAIL store_unsigned_nowrite: got %h want 11808001", rd); else passed++;
        access(1'b0, BASE + 1024, 3'b010, 32'd0, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL range_top: got err=%b rdata=%h want 1/0", er, rd); else passed++;
        access(1'b0, BASE - 4, 3'b010, 32'd0, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL range_wrap: got err=%b rdata=%h want 1/0", er, rd); else passed++;
        access(1'b1, BASE + 1020, 3'b010, 32'hCAFE_F00D, rd, er, lat);
        access(1'b0, BASE + 1020, 3'b010, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hCAFE_F00D || er) $display("FAIL last_word: got %h err=%b want cafef00d err=0", rd, er); else passed++;
    endtask

    task automatic test_wait_stall();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, BASE + 8, 3'b010, 32'h1234_5678, rd, er, lat);
        resp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1) $display("FAIL stall_c0_ready: got %b want 1", req_ready); else passed++;
        req_we = 1'b0; req_addr = BASE + 8; req_funct3 = 3'b010; req_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            checks++;
            if ({resp_valid, req_ready} !== 2'b00)
                $display("FAIL stall_wait_c%0d: got valid/ready=%b%b want 00", c, resp_valid, req_ready);
            else passed++;
        end
        for (int c = 4; c <= 8; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({resp_valid, req_ready, resp_err} !== 3'b100 || resp_rdata !== 32'h1234_5678)
                $display("FAIL stall_hold_c%0d: got valid/ready/err=%b%b%b rdata=%h want 100 12345678",
                         c, resp_valid, req_ready, resp_err, resp_rdata);
            else passed++;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL stall_release: got valid/ready=%b%b want 01", resp_valid, req_ready); else passed++;
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd; logic er; int lat;
        access(1'b0, BASE, 3'b010, 32'd0, rd, er, lat);
        req_we = 1'b1; req_addr = BASE; req_funct3 = 3'b010; req_wdata = 32'h5555_5555;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        checks++; if ({req_ready, resp_valid, resp_err} !== 3'b100) $display("FAIL midreset_ctrl: got ready/valid/err=%b%b%b want 100", req_ready, resp_valid, resp_err); else passed++;
        checks++; if (resp_rdata !== 32'd0) $display("FAIL midreset_rdata: got %h want 0", resp_rdata); else passed++;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        access(1'b0, BASE, 3'b010, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF || er) $display("FAIL midreset_nowrite: got %h want deadbeef", rd); else passed++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_wait_stall();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
